// File: rtl/chunked_subtractor.sv
// rtl/chunked_subtractor.sv - digit-serial subtractor, CHUNK bits per cycle
//
// Computes z = x - y - borrow_in over NCHUNK = WIDTH/CHUNK cycles, using a
// registered carry between chunks (subtraction as x + ~y + ~borrow_in).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands present          in_ready   block can accept operands
//   x, y       minuend, subtrahend       borrow_in  incoming borrow
//   out_valid  result present            out_ready  consumer accepts result
//   z          difference mod 2^WIDTH
//   borrow_out unsigned borrow (x < y + borrow_in)
//   overflow   signed two's-complement overflow
module chunked_subtractor #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, y_q, res_q, res_d, z_q;
  logic             carry_q, borrow_q, ovf_q;
  logic [CW-1:0]    cnt_q;
  logic [CHUNK:0]   sum;
  logic             last;

  // One chunk of x + ~y + carry; res_d is the result register with the
  // current chunk already merged in, so the final edge can load z directly.
  always_comb begin
    sum   = {1'b0, x_q[cnt_q*CHUNK +: CHUNK]}
          + {1'b0, ~y_q[cnt_q*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, carry_q};
    res_d = res_q;
    res_d[cnt_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    last  = (cnt_q == CW'(NCHUNK - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign z          = z_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      res_q    <= '0;
      z_q      <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q     <= x;
            y_q     <= y;
            carry_q <= ~borrow_in;   // borrow is an inverted carry
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          res_q   <= res_d;
          carry_q <= sum[CHUNK];
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            z_q      <= res_d;
            borrow_q <= ~sum[CHUNK];
            ovf_q    <= (x_q[WIDTH-1] != y_q[WIDTH-1]) &&
                        (res_d[WIDTH-1] != x_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/chunked_subtractor.md
Name: chunked_subtractor

Overview:
- Multi-cycle digit-serial subtractor: computes z = x - y - borrow_in over WIDTH/CHUNK clock cycles, CHUNK bits per cycle, with a registered borrow between chunks.
- Inverse-direction companion to the team's combinational prefix adder. Used where area matters more than latency.
- Valid/ready handshake on both input and output so it drops into streaming datapaths.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 2, bits processed per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived chunk count; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- x  input  WIDTH  minuend.
- y  input  WIDTH  subtrahend.
- borrow_in  input  1  incoming borrow.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- z  output  WIDTH  difference, modulo 2^WIDTH.
- borrow_out  output  1  1 when x < y + borrow_in (unsigned).
- overflow  output  1  signed two's-complement overflow of x - y - borrow_in.

Behaviour:
- One clock. Reset is synchronous and active-low: rst_n sampled low at a rising clk edge resets the block.
- Reset state: IDLE. z=0, borrow_out=0, overflow=0, out_valid=0, in_ready=1 (after the reset edge).
- FSM states: IDLE, BUSY, DONE. in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded directly from state.
- IDLE -> BUSY: on an edge with in_valid && in_ready.
  - Capture x, y and ~borrow_in as the initial internal carry.
  - Clear the chunk counter to 0.
- BUSY, each edge, chunk i = counter:
  - sum = x[i*CHUNK +: CHUNK] + ~y[i*CHUNK +: CHUNK] + carry, computed at CHUNK+1 bits.
  - Write the low CHUNK bits into the result register slice i.
  - Carry <= sum[CHUNK]. Counter increments.
- BUSY -> DONE: on the edge that processes chunk NCHUNK-1. On that same edge:
  - Load z from the completed result.
  - borrow_out <= ~final carry.
  - overflow <= (x[MSB] != y[MSB]) && (z[MSB] != x[MSB]), using captured operands.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge. With CHUNK=WIDTH, 1 cycle.
- DONE -> IDLE: on an edge with out_ready=1. No new operand is accepted on that edge; in_ready rises the following cycle. Throughput is one result per NCHUNK+2 cycles at best.
- Backpressure: while in DONE with out_ready=0, z, borrow_out and overflow are held stable and in_ready stays 0.
- z, borrow_out and overflow change only on entry to DONE or on reset. They keep the last result in IDLE and BUSY.
- Operand inputs are ignored outside the accepting edge. Changing x/y/borrow_in during BUSY has no effect.
- out_ready is ignored in IDLE and BUSY. in_valid is ignored in BUSY and DONE.
- Reset mid-operation, in BUSY or DONE: the in-flight result is discarded and the block returns to the reset state on that edge.
- Arithmetic is unsigned modulo 2^WIDTH. borrow_out is unsigned borrow; overflow is signed interpretation. They are independent.

Test Plan:
- WIDTH=8, CHUNK=2: accept x=0x5A, y=0x3C, borrow_in=0 -> out_valid 4 cycles later; z=0x1E, borrow_out=0, overflow=0.
- x=0x00, y=0x01, borrow_in=0 -> z=0xFF, borrow_out=1, overflow=0. x=0x80, y=0x01 -> z=0x7F, borrow_out=0, overflow=1.
- x=0x10, y=0x0F, borrow_in=1 -> z=0x00, borrow_out=0. x=0x00, y=0xFF, borrow_in=1 -> z=0x00, borrow_out=1.
- Hold out_ready=0 for 5 cycles after out_valid -> z, flags and out_valid stable, in_ready=0. Also toggle in_valid and x/y during BUSY -> result unaffected. Raise out_ready -> out_valid falls next cycle and in_ready rises.
- Assert rst_n=0 on the 2nd BUSY cycle -> next cycle in_ready=1, out_valid=0, z=0. A following operation with x=0x03, y=0x05 -> z=0xFE, borrow_out=1.
- Rebuild with CHUNK=8 and CHUNK=1: same vectors -> identical results, with latency 1 and 8 cycles respectively. Random sweep of 1000 operands matches a reference model.
